// File: rtl/video_timing_if.sv
// Raster timing bundle between the timing generator and the video pixel stage.
// The generator is the master. It takes the pixel clock enable and drives the
// coordinates, the delayed syncs and the strobes.
interface video_timing_if;
    logic        ce;
    logic [10:0] x;
    logic [9:0]  y;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        line_start;
    logic        frame_start;
    logic [7:0]  frame_cnt;

    modport master (
        input  ce,
        output x, y, hsync, vsync, de, line_start, frame_start, frame_cnt
    );

    modport slave (
        output ce,
        input  x, y, hsync, vsync, de, line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/video_timing.sv
// Free-running raster timing generator for the Pacman video pixel stage.
// x/y feed the pixel stage undelayed. de/hsync/vsync go through a PIPE_DELAY-deep
// delay line so that they line up with the registered RGB out of the pixel stage.
module video_timing #(
    parameter int VIDEO_WIDE = 0,
    parameter int H_FP       = 24,
    parameter int H_SYNC     = 80,
    parameter int H_BP       = 104,
    parameter int V_ACTIVE   = 576,
    parameter int V_FP       = 3,
    parameter int V_SYNC     = 5,
    parameter int V_BP       = 16,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int PIPE_DELAY = 1
) (
    input  logic           clk,
    input  logic           resetn,
    video_timing_if.master vif
);

    localparam int H_ACTIVE = (VIDEO_WIDE != 0) ? 1024 : 768;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Raster geometry, sized so that each comparison below is width-matched.
    localparam logic [10:0] X_LAST   = 11'(H_TOTAL - 1);
    localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [11:0] X_DE_END = 12'(H_ACTIVE);
    localparam logic [11:0] X_HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] X_HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] Y_DE_END = 11'(V_ACTIVE);
    localparam logic [10:0] Y_VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] Y_VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    // Reject geometries the coordinate ports cannot represent, and delay depths
    // outside the supported range.
    generate
        if (H_TOTAL > 2048) begin : g_bad_h_total
            $error("video_timing: H_TOTAL must not exceed 2048");
        end
        if (V_TOTAL > 1024) begin : g_bad_v_total
            $error("video_timing: V_TOTAL must not exceed 1024");
        end
        if ((PIPE_DELAY < 1) || (PIPE_DELAY > 8)) begin : g_bad_pipe_delay
            $error("video_timing: PIPE_DELAY must be in 1..8");
        end
    endgenerate

    logic [10:0] r_x;
    logic [9:0]  r_y;
    logic [7:0]  r_frame_cnt;
    logic        r_line_start;
    logic        r_frame_start;
    logic        r_de;
    logic        r_hsync;
    logic        r_vsync;

    logic        w_x_wrap;
    logic        w_y_wrap;
    logic [11:0] w_x12;
    logic [10:0] w_y11;
    logic        w_de_raw;
    logic        w_hs_raw;
    logic        w_vs_raw;
    logic [2:0]  w_raw;
    logic [2:0]  w_tail;

    assign w_x_wrap = (r_x == X_LAST);
    assign w_y_wrap = (r_y == Y_LAST);
    assign w_x12    = {1'b0, r_x};
    assign w_y11    = {1'b0, r_y};

    // Undelayed timing decoded from the current position. All three are active-high here.
    assign w_de_raw = (w_x12 < X_DE_END) && (w_y11 < Y_DE_END);
    assign w_hs_raw = (w_x12 >= X_HS_BEG) && (w_x12 < X_HS_END);
    assign w_vs_raw = (w_y11 >= Y_VS_BEG) && (w_y11 < Y_VS_END);
    assign w_raw    = {w_de_raw, w_hs_raw, w_vs_raw};

    // Pixel and line counters; frame_cnt counts completed frames.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_x         <= '0;
            r_y         <= '0;
            r_frame_cnt <= '0;
        end else if (vif.ce) begin
            if (w_x_wrap) begin
                r_x <= '0;
                if (w_y_wrap) begin
                    r_y         <= '0;
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end else begin
                    r_y <= r_y + 10'd1;
                end
            end else begin
                r_x <= r_x + 11'd1;
            end
        end
    end

    // Strobes fire on the edge where the counters wrap to 0. A ce=0 clock clears them.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= vif.ce && w_x_wrap;
            r_frame_start <= vif.ce && w_x_wrap && w_y_wrap;
        end
    end

    // The output register is the last delay stage. The stages ahead of it carry
    // PIPE_DELAY-1 cycles of active-high timing.
    generate
        if (PIPE_DELAY <= 1) begin : g_no_stage
            assign w_tail = w_raw;
        end else begin : g_stage
            logic [PIPE_DELAY-2:0][2:0] r_stage;

            // Shift the raw timing toward the output register on each pixel enable.
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    r_stage <= '0;
                end else if (vif.ce) begin
                    r_stage[0] <= w_raw;
                    for (int i = 1; i < PIPE_DELAY - 1; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign w_tail = r_stage[PIPE_DELAY-2];
        end
    endgenerate

    // Final delay stage; sync polarity is applied here so outputs are glitch-free.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_de    <= 1'b0;
            r_hsync <= ~HS_POL;
            r_vsync <= ~VS_POL;
        end else if (vif.ce) begin
            r_de    <= w_tail[2];
            r_hsync <= w_tail[1] ? HS_POL : ~HS_POL;
            r_vsync <= w_tail[0] ? VS_POL : ~VS_POL;
        end
    end

    assign vif.x           = r_x;
    assign vif.y           = r_y;
    assign vif.de          = r_de;
    assign vif.hsync       = r_hsync;
    assign vif.vsync       = r_vsync;
    assign vif.line_start  = r_line_start;
    assign vif.frame_start = r_frame_start;
    assign vif.frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing. Three instances run side by side:
//   dut0: default geometry, PIPE_DELAY=1
//   dut1: tiny raster 774x8, active-high syncs, PIPE_DELAY=8 (lets whole frames fit)
//   dut2: VIDEO_WIDE=1, PIPE_DELAY=3
// Each instance has a behavioural raster model. Its delayed timing goes through a
// scoreboard queue that is pushed on every pixel enable and popped for the expected output.
module tb_video_timing;

    logic clk = 1'b0;
    logic resetn;
    logic ce;

    always #5 clk = ~clk;

    video_timing_if vif0 ();
    video_timing_if vif1 ();
    video_timing_if vif2 ();

    assign vif0.ce = ce;
    assign vif1.ce = ce;
    assign vif2.ce = ce;

    video_timing u_dut0 (.clk(clk), .resetn(resetn), .vif(vif0));

    video_timing #(
        .VIDEO_WIDE(0), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DELAY(8)
    ) u_dut1 (.clk(clk), .resetn(resetn), .vif(vif1));

    video_timing #(
        .VIDEO_WIDE(1), .PIPE_DELAY(3)
    ) u_dut2 (.clk(clk), .resetn(resetn), .vif(vif2));

    // Per-instance geometry, written out independently of the RTL.
    localparam int HA  [3] = '{768, 768, 1024};
    localparam int HFP [3] = '{24, 2, 24};
    localparam int HSY [3] = '{80, 3, 80};
    localparam int HBP [3] = '{104, 1, 104};
    localparam int VA  [3] = '{576, 4, 576};
    localparam int VFP [3] = '{3, 1, 3};
    localparam int VSY [3] = '{5, 2, 5};
    localparam int VBP [3] = '{16, 1, 16};
    localparam bit HP  [3] = '{1'b0, 1'b1, 1'b0};
    localparam bit VP  [3] = '{1'b0, 1'b1, 1'b0};
    localparam int PD  [3] = '{1, 8, 3};

    // Observed outputs gathered into arrays so a loop can walk the instances.
    logic [10:0] ax  [3];
    logic [9:0]  ay  [3];
    logic        ade [3];
    logic        ahs [3];
    logic        avs [3];
    logic        als [3];
    logic        afs [3];
    logic [7:0]  afc [3];

    assign ax[0] = vif0.x;  assign ay[0] = vif0.y;  assign ade[0] = vif0.de;
    assign ahs[0] = vif0.hsync; assign avs[0] = vif0.vsync;
    assign als[0] = vif0.line_start; assign afs[0] = vif0.frame_start; assign afc[0] = vif0.frame_cnt;
    assign ax[1] = vif1.x;  assign ay[1] = vif1.y;  assign ade[1] = vif1.de;
    assign ahs[1] = vif1.hsync; assign avs[1] = vif1.vsync;
    assign als[1] = vif1.line_start; assign afs[1] = vif1.frame_start; assign afc[1] = vif1.frame_cnt;
    assign ax[2] = vif2.x;  assign ay[2] = vif2.y;  assign ade[2] = vif2.de;
    assign ahs[2] = vif2.hsync; assign avs[2] = vif2.vsync;
    assign als[2] = vif2.line_start; assign afs[2] = vif2.frame_start; assign afc[2] = vif2.frame_cnt;

    // Model state and scoreboard.
    int         mx [3];
    int         my [3];
    int         mfc[3];
    bit         mls[3];
    bit         mfs[3];
    bit         mde[3];
    bit         mhs[3];
    bit         mvs[3];
    logic [2:0] sb [3][$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic model_edge(input bit rn, input bit c);
        for (int d = 0; d < 3; d++) begin
            int         ht;
            int         vt;
            logic [2:0] raw;
            logic [2:0] e;
            ht = HA[d] + HFP[d] + HSY[d] + HBP[d];
            vt = VA[d] + VFP[d] + VSY[d] + VBP[d];
            if (!rn) begin
                mx[d] = 0; my[d] = 0; mfc[d] = 0; mls[d] = 0; mfs[d] = 0;
                sb[d].delete();
                for (int i = 0; i < PD[d] - 1; i++) sb[d].push_back(3'b000);
                mde[d] = 1'b0; mhs[d] = ~HP[d]; mvs[d] = ~VP[d];
            end else if (c) begin
                raw[2] = (mx[d] < HA[d]) && (my[d] < VA[d]);
                raw[1] = (mx[d] >= HA[d] + HFP[d]) && (mx[d] < HA[d] + HFP[d] + HSY[d]);
                raw[0] = (my[d] >= VA[d] + VFP[d]) && (my[d] < VA[d] + VFP[d] + VSY[d]);
                sb[d].push_back(raw);
                e = sb[d].pop_front();
                mde[d] = e[2];
                mhs[d] = e[1] ? HP[d] : ~HP[d];
                mvs[d] = e[0] ? VP[d] : ~VP[d];
                mls[d] = (mx[d] == ht - 1);
                mfs[d] = (mx[d] == ht - 1) && (my[d] == vt - 1);
                if (mx[d] == ht - 1) begin
                    mx[d] = 0;
                    if (my[d] == vt - 1) begin
                        my[d]  = 0;
                        mfc[d] = (mfc[d] + 1) % 256;
                    end else begin
                        my[d] = my[d] + 1;
                    end
                end else begin
                    mx[d] = mx[d] + 1;
                end
            end else begin
                mls[d] = 1'b0;
                mfs[d] = 1'b0;
            end
        end
    endtask

    // Drive inputs, take one active edge, advance the model, settle for sampling.
    task automatic tick(input bit rn, input bit c);
        resetn = rn;
        ce     = c;
        @(posedge clk);
        model_edge(rn, c);
        if (!rn) cyc = 0;
        else     cyc++;
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b1);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ax[d] !== 11'd0 || ay[d] !== 10'd0 || afc[d] !== 8'd0 || als[d] !== 1'b0 ||
                afs[d] !== 1'b0 || ade[d] !== 1'b0 || ahs[d] !== ~HP[d] || avs[d] !== ~VP[d]) begin
                errors++;
                $display("FAIL reset_state dut%0d: got x=%0d y=%0d fc=%0d ls=%b fs=%b de=%b hs=%b vs=%b, want 0 0 0 0 0 0 %b %b",
                         d, ax[d], ay[d], afc[d], als[d], afs[d], ade[d], ahs[d], avs[d], ~HP[d], ~VP[d]);
            end
        end
    endtask

    task automatic test_line();
        int bad = 0;
        int de_n[3], de_f[3], de_l[3], hs_n[3], hs_f[3], hs_l[3];
        for (int d = 0; d < 3; d++) begin
            de_n[d] = 0; de_f[d] = -1; de_l[d] = -1; hs_n[d] = 0; hs_f[d] = -1; hs_l[d] = -1;
        end
        for (int k = 0; k < 1962 && bad < 5; k++) begin
            tick(1'b1, 1'b1);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (ax[d] !== 11'(mx[d]) || ay[d] !== 10'(my[d]) || ade[d] !== mde[d] || ahs[d] !== mhs[d] ||
                    avs[d] !== mvs[d] || als[d] !== mls[d] || afs[d] !== mfs[d] || afc[d] !== 8'(mfc[d])) begin
                    errors++; bad++;
                    $display("FAIL line_model dut%0d cyc=%0d: got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, want %0d %0d %b %b %b %b %b %0d",
                             d, cyc, ax[d], ay[d], ade[d], ahs[d], avs[d], als[d], afs[d], afc[d],
                             mx[d], my[d], mde[d], mhs[d], mvs[d], mls[d], mfs[d], mfc[d]);
                end
                if (ay[d] == 10'd0) begin
                    if (ade[d] === 1'b1) begin
                        de_n[d]++; if (de_f[d] < 0) de_f[d] = int'(ax[d]); de_l[d] = int'(ax[d]);
                    end
                    if (ahs[d] === 1'b0) begin
                        hs_n[d]++; if (hs_f[d] < 0) hs_f[d] = int'(ax[d]); hs_l[d] = int'(ax[d]);
                    end
                end
            end
            if (cyc == 1) begin
                checks++;
                if (ax[0] !== 11'd1) begin
                    errors++; $display("FAIL first_step: x=%0d, want 1", ax[0]);
                end
            end
            if (cyc == 976) begin
                checks++;
                if (ax[0] !== 11'd0 || ay[0] !== 10'd1 || als[0] !== 1'b1) begin
                    errors++; $display("FAIL line_wrap: x=%0d y=%0d ls=%b, want 0 1 1", ax[0], ay[0], als[0]);
                end
            end
            if (cyc == 977) begin
                checks++;
                if (als[0] !== 1'b0) begin
                    errors++; $display("FAIL line_strobe_len: ls=%b, want 0", als[0]);
                end
            end
        end
        checks++;
        if (de_n[0] != 768 || de_f[0] != 1 || de_l[0] != 768) begin
            errors++; $display("FAIL de_default: n=%0d first=%0d last=%0d, want 768 1 768", de_n[0], de_f[0], de_l[0]);
        end
        checks++;
        if (hs_n[0] != 80 || hs_f[0] != 793 || hs_l[0] != 872) begin
            errors++; $display("FAIL hsync_default: n=%0d first=%0d last=%0d, want 80 793 872", hs_n[0], hs_f[0], hs_l[0]);
        end
        checks++;
        if (de_n[2] != 1024 || de_f[2] != 3 || de_l[2] != 1026) begin
            errors++; $display("FAIL de_wide: n=%0d first=%0d last=%0d, want 1024 3 1026", de_n[2], de_f[2], de_l[2]);
        end
        checks++;
        if (hs_n[2] != 80 || hs_f[2] != 1051 || hs_l[2] != 1130) begin
            errors++; $display("FAIL hsync_wide: n=%0d first=%0d last=%0d, want 80 1051 1130", hs_n[2], hs_f[2], hs_l[2]);
        end
    endtask

    task automatic test_frames();
        int bad = 0;
        int fs_n = 0;
        int fs_at[2] = '{-1, -1};
        int vs_n = 0;
        int de_blank = 0;
        while (cyc < 2 * 6192 + 2 && bad < 5) begin
            tick(1'b1, 1'b1);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (ax[d] !== 11'(mx[d]) || ay[d] !== 10'(my[d]) || ade[d] !== mde[d] || ahs[d] !== mhs[d] ||
                    avs[d] !== mvs[d] || als[d] !== mls[d] || afs[d] !== mfs[d] || afc[d] !== 8'(mfc[d])) begin
                    errors++; bad++;
                    $display("FAIL frame_model dut%0d cyc=%0d: got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, want %0d %0d %b %b %b %b %b %0d",
                             d, cyc, ax[d], ay[d], ade[d], ahs[d], avs[d], als[d], afs[d], afc[d],
                             mx[d], my[d], mde[d], mhs[d], mvs[d], mls[d], mfs[d], mfc[d]);
                end
            end
            if (afs[1] === 1'b1) begin
                if (fs_n < 2) fs_at[fs_n] = cyc;
                fs_n++;
            end
            if (avs[1] === 1'b1) vs_n++;
            if (ay[1] >= 10'd4 && ax[1] >= 11'd8 && ade[1] !== 1'b0) de_blank++;
        end
        checks++;
        if (fs_n != 2 || fs_at[0] != 6192 || fs_at[1] != 12384) begin
            errors++; $display("FAIL frame_start: pulses=%0d at %0d,%0d, want 2 at 6192,12384", fs_n, fs_at[0], fs_at[1]);
        end
        checks++;
        if (afc[1] !== 8'd2) begin
            errors++; $display("FAIL frame_cnt: got %0d, want 2", afc[1]);
        end
        checks++;
        if (vs_n != 3096) begin
            errors++; $display("FAIL vsync_width: active cycles=%0d, want 3096", vs_n);
        end
        checks++;
        if (de_blank != 0) begin
            errors++; $display("FAIL de_in_blanking: cycles=%0d, want 0", de_blank);
        end
    endtask

    task automatic test_ce_toggle();
        int bad = 0;
        int ls_seen = 0;
        logic [10:0] px [3];
        logic [9:0]  py [3];
        logic        pde[3], phs[3], pvs[3], pls[3];
        logic [7:0]  pfc[3];
        for (int k = 0; k < 2000 && bad < 5; k++) begin
            bit c;
            c = (k % 2 == 0);
            tick(1'b1, c);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (ax[d] !== 11'(mx[d]) || ay[d] !== 10'(my[d]) || ade[d] !== mde[d] || ahs[d] !== mhs[d] ||
                    avs[d] !== mvs[d] || als[d] !== mls[d] || afs[d] !== mfs[d] || afc[d] !== 8'(mfc[d])) begin
                    errors++; bad++;
                    $display("FAIL ce_model dut%0d cyc=%0d: got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, want %0d %0d %b %b %b %b %b %0d",
                             d, cyc, ax[d], ay[d], ade[d], ahs[d], avs[d], als[d], afs[d], afc[d],
                             mx[d], my[d], mde[d], mhs[d], mvs[d], mls[d], mfs[d], mfc[d]);
                end
                if (!c) begin
                    checks++;
                    if (ax[d] !== px[d] || ay[d] !== py[d] || ade[d] !== pde[d] || ahs[d] !== phs[d] ||
                        avs[d] !== pvs[d] || afc[d] !== pfc[d] || als[d] !== 1'b0 || afs[d] !== 1'b0) begin
                        errors++; bad++;
                        $display("FAIL ce_hold dut%0d cyc=%0d: got x=%0d y=%0d de=%b hs=%b vs=%b fc=%0d ls=%b fs=%b, want %0d %0d %b %b %b %0d 0 0",
                                 d, cyc, ax[d], ay[d], ade[d], ahs[d], avs[d], afc[d], als[d], afs[d],
                                 px[d], py[d], pde[d], phs[d], pvs[d], pfc[d]);
                    end
                end
                if (k > 0) begin
                    checks++;
                    if (als[d] === 1'b1 && pls[d] === 1'b1) begin
                        errors++; bad++;
                        $display("FAIL strobe_len dut%0d cyc=%0d: line_start=%b two clocks, want single", d, cyc, als[d]);
                    end
                end
                if (d == 1 && als[d] === 1'b1) ls_seen++;
                px[d] = ax[d]; py[d] = ay[d]; pde[d] = ade[d]; phs[d] = ahs[d];
                pvs[d] = avs[d]; pfc[d] = afc[d]; pls[d] = als[d];
            end
        end
        checks++;
        if (ls_seen == 0) begin
            errors++; $display("FAIL ce_line_start: pulses=%0d, want at least 1", ls_seen);
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        int bad = 0;
        while (!(ay[1] == 10'd3 && ax[1] == 11'd500) && n < 8000) begin
            tick(1'b1, 1'b1);
            n++;
        end
        checks++;
        if (n >= 8000) begin
            errors++; $display("FAIL mid_reset_reach: x=%0d y=%0d after %0d cycles, want x=500 y=3", ax[1], ay[1], n);
        end
        checks++;
        if (afc[1] !== 8'(mfc[1]) || afc[1] === 8'd0) begin
            errors++; $display("FAIL pre_reset_fc: got %0d, want %0d (nonzero)", afc[1], mfc[1]);
        end
        // Reset with ce low: reset must still win.
        tick(1'b0, 1'b0);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ax[d] !== 11'd0 || ay[d] !== 10'd0 || ade[d] !== 1'b0 || ahs[d] !== ~HP[d] || avs[d] !== ~VP[d] ||
                afc[d] !== 8'd0 || als[d] !== 1'b0 || afs[d] !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset dut%0d: got x=%0d y=%0d de=%b hs=%b vs=%b fc=%0d ls=%b fs=%b, want 0 0 0 %b %b 0 0 0",
                         d, ax[d], ay[d], ade[d], ahs[d], avs[d], afc[d], als[d], afs[d], ~HP[d], ~VP[d]);
            end
        end
        tick(1'b1, 1'b1);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ax[d] !== 11'd1 || ay[d] !== 10'd0 || als[d] !== 1'b0 || afs[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_exit dut%0d: got x=%0d y=%0d ls=%b fs=%b, want 1 0 0 0", d, ax[d], ay[d], als[d], afs[d]);
            end
        end
        while (cyc < 6192 + 4 && bad < 5) begin
            tick(1'b1, 1'b1);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (ax[d] !== 11'(mx[d]) || ay[d] !== 10'(my[d]) || ade[d] !== mde[d] || ahs[d] !== mhs[d] ||
                    avs[d] !== mvs[d] || als[d] !== mls[d] || afs[d] !== mfs[d] || afc[d] !== 8'(mfc[d])) begin
                    errors++; bad++;
                    $display("FAIL restart_model dut%0d cyc=%0d: got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, want %0d %0d %b %b %b %b %b %0d",
                             d, cyc, ax[d], ay[d], ade[d], ahs[d], avs[d], als[d], afs[d], afc[d],
                             mx[d], my[d], mde[d], mhs[d], mvs[d], mls[d], mfs[d], mfc[d]);
                end
            end
        end
        checks++;
        if (afc[1] !== 8'd1) begin
            errors++; $display("FAIL restart_fc: got %0d, want 1", afc[1]);
        end
    endtask

    initial begin
        resetn = 1'b0;
        ce     = 1'b1;
        test_reset();
        test_line();
        test_frames();
        test_ce_toggle();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
